// File: rtl/ipml_prefetch_fifo_pkg.sv
// rtl/ipml_prefetch_fifo_pkg.sv - shared constants and helpers for the sync prefetch FIFO
//   legal RAM read latencies, skid depth and occupancy width helpers.
package ipml_prefetch_fifo_pkg;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  // Wide enough for 0..SKID_D at the largest legal read latency.
  localparam int CNT_W = 3;

  function automatic bit rd_lat_legal(input int rd_lat);
    return (rd_lat >= RD_LAT_MIN) && (rd_lat <= RD_LAT_MAX);
  endfunction

  // One slot per in-flight read plus one for the word being held at the head.
  function automatic int skid_depth(input int rd_lat);
    return rd_lat + 1;
  endfunction

  // Total occupancy reaches 2**addr_w + skid_depth, so one extra bit over ram_cnt.
  function automatic int level_w(input int addr_w);
    return addr_w + 2;
  endfunction

endpackage

// File: rtl/ipml_prefetch_skid_buf.sv
// rtl/ipml_prefetch_skid_buf.sv - small register FIFO holding prefetched RAM words
//   clk, rst, flush       : clock, sync active-high reset, sync clear
//   land_tdata/tvalid     : word arriving from the RAM read pipeline (space guaranteed by caller)
//   head_tdata/tvalid     : registered head-of-queue word
//   head_tready           : consumer ready; pop = head_tvalid & head_tready
//   count                 : words currently held
module ipml_prefetch_skid_buf
  import ipml_prefetch_fifo_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [DATA_W-1:0] land_tdata,
  input  logic              land_tvalid,
  output logic [DATA_W-1:0] head_tdata,
  output logic              head_tvalid,
  input  logic              head_tready,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] slot_q [DEPTH];
  logic [DATA_W-1:0] slot_d [DEPTH];
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [CNT_W-1:0]  wr_idx;
  logic              pop;

  assign head_tvalid = (cnt_q != '0);
  assign head_tdata  = slot_q[0];
  assign count       = cnt_q;
  assign pop         = head_tvalid & head_tready;

  // Slot 0 is always the head; a pop shifts everything down one place and an
  // arriving word lands just past the surviving entries.
  always_comb begin
    wr_idx = cnt_q - CNT_W'(pop);
    cnt_d  = cnt_q + CNT_W'(land_tvalid) - CNT_W'(pop);
    for (int i = 0; i < DEPTH; i++) begin
      slot_d[i] = slot_q[i];
    end
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        slot_d[i] = slot_q[i + 1];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (land_tvalid && (wr_idx == CNT_W'(i))) begin
        slot_d[i] = land_tdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

endmodule

// File: rtl/ipml_sync_prefetch_fifo_v2_0.sv
// rtl/ipml_sync_prefetch_fifo_v2_0.sv - single-clock first-word-fall-through FIFO over an inferred SDP RAM
//   clk, rst, flush            : clock, sync active-high reset, sync clear (error flags kept)
//   wr_data, wr_en, wr_vld     : write side; word stored on wr_en & wr_vld
//   almost_full                : RAM word count >= AF_TH
//   rd_data, rd_vld, rd_en     : read side; pop on rd_en & rd_vld
//   almost_empty               : total occupancy <= AE_TH
//   err_ovf, err_udf           : sticky write-while-full / read-while-empty, cleared by rst only
//   level                      : total occupancy, present only with PREFETCH_FIFO_LEVEL_EN defined
module ipml_sync_prefetch_fifo_v2_0
  import ipml_prefetch_fifo_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1,
  parameter int AF_TH  = 2**ADDR_W - 4,
  parameter int AE_TH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  output logic              wr_vld,
  output logic              almost_full,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_en,
  output logic              rd_vld,
  output logic              almost_empty,
  output logic              err_ovf,
  output logic              err_udf
`ifdef PREFETCH_FIFO_LEVEL_EN
  ,
  output logic [ADDR_W+1:0] level
`endif
);

  localparam int               SKID_D   = skid_depth(RD_LAT);
  localparam int               LVL_W    = level_w(ADDR_W);
  localparam logic [ADDR_W:0]  FULL_CNT = (ADDR_W+1)'(2**ADDR_W);
  localparam logic [ADDR_W:0]  AF_CNT   = (ADDR_W+1)'(AF_TH);
  localparam logic [LVL_W-1:0] AE_CNT   = LVL_W'(AE_TH);
  localparam logic [CNT_W-1:0] SKID_CNT = CNT_W'(SKID_D);

  if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
    $error("ipml_sync_prefetch_fifo_v2_0: RD_LAT must be 1 or 2");
  end

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   ram_cnt;
  logic [RD_LAT-1:0] vld_pipe;
  logic [DATA_W-1:0] rd_pipe [RD_LAT];
  logic [CNT_W-1:0]  skid_cnt;
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W-1:0]  credit;
  logic              wr_fire;
  logic              rd_issue;
  logic              pop;

  assign wr_vld      = (ram_cnt != FULL_CNT);
  assign almost_full = (ram_cnt >= AF_CNT);
  // flush wins over a same-cycle write: the word is dropped silently.
  assign wr_fire     = wr_en & wr_vld & ~flush;
  assign pop         = rd_en & rd_vld;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CNT_W'(vld_pipe[i]);
    end
  end

  // Only issue a read if the skid is guaranteed a free slot when it lands.
  // The pop term lets a draining head free its slot in the same cycle, which is
  // what keeps streaming at one word per clock. ram_cnt is sampled before this
  // cycle's write, so the address being written is never read in the same cycle.
  assign credit   = skid_cnt + inflight - CNT_W'(pop);
  assign rd_issue = (ram_cnt != '0) & (credit < SKID_CNT) & ~flush;

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // RAM output plus optional pipeline register; aligned with vld_pipe.
  always_ff @(posedge clk) begin
    if (rd_issue) begin
      rd_pipe[0] <= mem[rd_ptr];
    end
    for (int i = 1; i < RD_LAT; i++) begin
      rd_pipe[i] <= rd_pipe[i - 1];
    end
  end

  // Clearing vld_pipe on flush is what discards reads already in flight.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ram_cnt  <= '0;
      vld_pipe <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (rd_issue) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      ram_cnt     <= ram_cnt + (ADDR_W+1)'(wr_fire) - (ADDR_W+1)'(rd_issue);
      vld_pipe[0] <= rd_issue;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i - 1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      if (wr_en && !wr_vld && !flush) begin
        err_ovf <= 1'b1;
      end
      if (rd_en && !rd_vld) begin
        err_udf <= 1'b1;
      end
    end
  end

  ipml_prefetch_skid_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (SKID_D)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .land_tdata  (rd_pipe[RD_LAT - 1]),
    .land_tvalid (vld_pipe[RD_LAT - 1]),
    .head_tdata  (rd_data),
    .head_tvalid (rd_vld),
    .head_tready (rd_en),
    .count       (skid_cnt)
  );

`ifdef PREFETCH_FIFO_LEVEL_EN
  // Up/down counter equal to ram_cnt + inflight + skid_cnt, one cycle after the event.
  logic [LVL_W-1:0] level_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      level_q <= '0;
    end else begin
      level_q <= level_q + LVL_W'(wr_fire) - LVL_W'(pop);
    end
  end

  assign level        = level_q;
  assign almost_empty = (level_q <= AE_CNT);
`else
  logic [LVL_W-1:0] occupancy;

  assign occupancy    = LVL_W'(ram_cnt) + LVL_W'(inflight) + LVL_W'(skid_cnt);
  assign almost_empty = (occupancy <= AE_CNT);
`endif

endmodule

// File: tb/tb_ipml_sync_prefetch_fifo_v2_0.sv
// tb/tb_ipml_sync_prefetch_fifo_v2_0.sv - directed self-checking bench for the sync prefetch FIFO
`timescale 1ns/1ps
module tb_ipml_sync_prefetch_fifo_v2_0;

  localparam int AW1 = 10;
  localparam int AW2 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // u1: ADDR_W=10, RD_LAT=1 (SKID_D=2)
  logic        rst1 = 1'b0, flush1 = 1'b0, wr_en1 = 1'b0, rd_en1 = 1'b0;
  logic [31:0] wr_data1 = '0;
  logic        wr_vld1, af1, rd_vld1, ae1, ovf1, udf1;
  logic [31:0] rd_data1;
  // u2: ADDR_W=4, RD_LAT=2 (SKID_D=3, AF_TH=12)
  logic        rst2 = 1'b0, flush2 = 1'b0, wr_en2 = 1'b0, rd_en2 = 1'b0;
  logic [31:0] wr_data2 = '0;
  logic        wr_vld2, af2, rd_vld2, ae2, ovf2, udf2;
  logic [31:0] rd_data2;
`ifdef PREFETCH_FIFO_LEVEL_EN
  logic [AW1+1:0] level1;
  logic [AW2+1:0] level2;
`endif

  ipml_sync_prefetch_fifo_v2_0 #(.DATA_W(32), .ADDR_W(AW1), .RD_LAT(1)) u1 (
    .clk(clk), .rst(rst1), .flush(flush1), .wr_data(wr_data1), .wr_en(wr_en1),
    .wr_vld(wr_vld1), .almost_full(af1), .rd_data(rd_data1), .rd_en(rd_en1),
    .rd_vld(rd_vld1), .almost_empty(ae1), .err_ovf(ovf1), .err_udf(udf1)
`ifdef PREFETCH_FIFO_LEVEL_EN
    , .level(level1)
`endif
  );

  ipml_sync_prefetch_fifo_v2_0 #(.DATA_W(32), .ADDR_W(AW2), .RD_LAT(2)) u2 (
    .clk(clk), .rst(rst2), .flush(flush2), .wr_data(wr_data2), .wr_en(wr_en2),
    .wr_vld(wr_vld2), .almost_full(af2), .rd_data(rd_data2), .rd_en(rd_en2),
    .rd_vld(rd_vld2), .almost_empty(ae2), .err_ovf(ovf2), .err_udf(udf2)
`ifdef PREFETCH_FIFO_LEVEL_EN
    , .level(level2)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst(input int sel);
    if (sel == 1) rst1 = 1'b1; else rst2 = 1'b1;
    tick();
    rst1 = 1'b0;
    rst2 = 1'b0;
  endtask

  task automatic push2(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      wr_en2 = 1'b1;
      wr_data2 = base + 32'(i);
      tick();
    end
    wr_en2 = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_reset();
    rst1 = 1'b1; rst2 = 1'b1;
    tick(); tick();
    rst1 = 1'b0; rst2 = 1'b0;
    tick();
    tests_run++;
    if ({wr_vld1, rd_vld1, ae1, af1, ovf1, udf1} !== 6'b101000) begin
      tests_failed++;
      $display("FAIL reset_flags_u1: got %b want 101000", {wr_vld1, rd_vld1, ae1, af1, ovf1, udf1});
    end
    tests_run++;
    if ({wr_vld2, rd_vld2, ae2, af2, ovf2, udf2} !== 6'b101000) begin
      tests_failed++;
      $display("FAIL reset_flags_u2: got %b want 101000", {wr_vld2, rd_vld2, ae2, af2, ovf2, udf2});
    end
    tests_run++;
    if (rd_data1 !== 32'h0 || rd_data2 !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_rd_data: got %h/%h want 0/0", rd_data1, rd_data2);
    end
  endtask

  task automatic test_latency();
    wr_en1 = 1'b1; wr_data1 = 32'hA5A5_0001;
    tick();
    wr_en1 = 1'b0;
    tests_run++;
    if (rd_vld1 !== 1'b0) begin
      tests_failed++; $display("FAIL latency_cycle1: rd_vld got %b want 0", rd_vld1);
    end
    tick();
    tests_run++;
    if (rd_vld1 !== 1'b0) begin
      tests_failed++; $display("FAIL latency_cycle2: rd_vld got %b want 0", rd_vld1);
    end
    tick();
    tests_run++;
    if ({rd_vld1, rd_data1} !== {1'b1, 32'hA5A5_0001}) begin
      tests_failed++; $display("FAIL latency_cycle3: got vld=%b data=%h want vld=1 data=a5a50001", rd_vld1, rd_data1);
    end
    rd_en1 = 1'b1;
    tick();
    rd_en1 = 1'b0;
    tests_run++;
    if ({rd_vld1, ae1} !== 2'b01) begin
      tests_failed++; $display("FAIL latency_pop: got vld,ae=%b want 01", {rd_vld1, ae1});
    end
  endtask

  task automatic test_thresholds();
    push2(2, 32'h0);
    tests_run++;
    if ({ae2, af2} !== 2'b10) begin
      tests_failed++; $display("FAIL thr_occ2: got ae,af=%b want 10", {ae2, af2});
    end
    push2(1, 32'h2);
    tests_run++;
    if ({ae2, af2} !== 2'b00) begin
      tests_failed++; $display("FAIL thr_occ3: got ae,af=%b want 00", {ae2, af2});
    end
    push2(11, 32'h3);
    tests_run++;
    if ({af2, wr_vld2} !== 2'b01) begin
      tests_failed++; $display("FAIL thr_ram11: got af,wr_vld=%b want 01", {af2, wr_vld2});
    end
    push2(1, 32'he);
    tests_run++;
    if ({af2, wr_vld2} !== 2'b11) begin
      tests_failed++; $display("FAIL thr_ram12: got af,wr_vld=%b want 11", {af2, wr_vld2});
    end
    push2(4, 32'hf);
    tests_run++;
    if ({af2, wr_vld2, ovf2} !== 3'b100) begin
      tests_failed++; $display("FAIL thr_ram16: got af,wr_vld,ovf=%b want 100", {af2, wr_vld2, ovf2});
    end
  endtask

  task automatic test_fill_overflow();
    int accepted;
    int drained;
    accepted = 0;
    drained = 0;
    for (int c = 0; c < 1200 && wr_vld1; c++) begin
      wr_en1 = 1'b1;
      wr_data1 = 32'(c);
      tick();
      accepted++;
`ifdef PREFETCH_FIFO_LEVEL_EN
      tests_run++;
      if (level1 !== (AW1+2)'(accepted)) begin
        tests_failed++; $display("FAIL fill_level: got %0d want %0d", level1, accepted);
      end
`endif
    end
    wr_en1 = 1'b0;
    tests_run++;
    if (accepted != 1026) begin
      tests_failed++; $display("FAIL fill_accepted: got %0d want 1026", accepted);
    end
    tests_run++;
    if ({wr_vld1, af1, ovf1} !== 3'b010) begin
      tests_failed++; $display("FAIL fill_full_flags: got wr_vld,af,ovf=%b want 010", {wr_vld1, af1, ovf1});
    end
    wr_en1 = 1'b1; wr_data1 = 32'hDEAD_BEEF;
    tick();
    wr_en1 = 1'b0;
    tests_run++;
    if ({ovf1, udf1} !== 2'b10) begin
      tests_failed++; $display("FAIL fill_ovf: got ovf,udf=%b want 10", {ovf1, udf1});
    end
    for (int c = 0; c < 1200; c++) begin
      rd_en1 = rd_vld1 && (drained < 1026);
      if (rd_en1) begin
        tests_run++;
        if (rd_data1 !== 32'(drained)) begin
          tests_failed++; $display("FAIL drain_data: got %h want %h", rd_data1, 32'(drained));
        end
        drained++;
      end
      tick();
    end
    rd_en1 = 1'b0;
    tests_run++;
    if (drained != 1026) begin
      tests_failed++; $display("FAIL drain_count: got %0d want 1026", drained);
    end
    tests_run++;
    if ({rd_vld1, ae1} !== 2'b01) begin
      tests_failed++; $display("FAIL drain_empty (dropped word stored?): got vld,ae=%b want 01", {rd_vld1, ae1});
    end
`ifdef PREFETCH_FIFO_LEVEL_EN
    tests_run++;
    if (level1 !== '0) begin
      tests_failed++; $display("FAIL drain_level: got %0d want 0", level1);
    end
`endif
  endtask

  task automatic test_stream(input int sel);
    int lat;
    logic v;
    logic [31:0] d;
    logic [31:0] base;
    lat  = (sel == 1) ? 3 : 4;
    base = (sel == 1) ? 32'h1000_0000 : 32'h2000_0000;
    pulse_rst(sel);
    for (int c = 0; c < 520; c++) begin
      if (sel == 1) begin
        v = rd_vld1; d = rd_data1;
        wr_en1 = (c < 500); wr_data1 = base + 32'(c); rd_en1 = 1'b1;
      end else begin
        v = rd_vld2; d = rd_data2;
        wr_en2 = (c < 500); wr_data2 = base + 32'(c); rd_en2 = 1'b1;
      end
      tests_run++;
      if (c < lat || c >= 500 + lat) begin
        if (v !== 1'b0) begin
          tests_failed++; $display("FAIL stream%0d_idle c=%0d: rd_vld got %b want 0", sel, c, v);
        end
      end else if ({v, d} !== {1'b1, base + 32'(c - lat)}) begin
        tests_failed++;
        $display("FAIL stream%0d_word c=%0d: got vld=%b data=%h want vld=1 data=%h", sel, c, v, d, base + 32'(c - lat));
      end
      tick();
    end
    wr_en1 = 1'b0; rd_en1 = 1'b0;
    wr_en2 = 1'b0; rd_en2 = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] q[$];
    int sent;
    int recvd;
    logic hold;
    logic [31:0] hold_data;
    logic [31:0] exp;
    sent = 0; recvd = 0; hold = 1'b0; hold_data = '0;
    pulse_rst(2);
    for (int c = 0; c < 60000 && recvd < 10000; c++) begin
      if (hold) begin
        tests_run++;
        if ({rd_vld2, rd_data2} !== {1'b1, hold_data}) begin
          tests_failed++; $display("FAIL bp_hold: got vld=%b data=%h want vld=1 data=%h", rd_vld2, rd_data2, hold_data);
        end
      end
      rd_en2   = 1'($urandom_range(0, 1));
      wr_en2   = (sent < 10000) && wr_vld2 && ($urandom_range(0, 3) != 0);
      wr_data2 = 32'h3000_0000 + 32'(sent);
      if (wr_en2) begin
        q.push_back(wr_data2);
        sent++;
      end
      if (rd_en2 && rd_vld2) begin
        tests_run++;
        exp = (q.size() != 0) ? q.pop_front() : 32'hXXXX_XXXX;
        if (rd_data2 !== exp) begin
          tests_failed++; $display("FAIL bp_order: got %h want %h", rd_data2, exp);
        end
        recvd++;
      end
      hold = rd_vld2 && !rd_en2;
      hold_data = rd_data2;
      tick();
    end
    wr_en2 = 1'b0; rd_en2 = 1'b0;
    tests_run++;
    if (recvd != 10000) begin
      tests_failed++; $display("FAIL bp_count: got %0d want 10000", recvd);
    end
  endtask

  task automatic test_flush();
    wr_en1 = 1'b1; wr_data1 = 32'h111; tick();
    wr_data1 = 32'h222; tick();
    wr_data1 = 32'h333; tick();
    tests_run++;
    if ({rd_vld1, rd_data1} !== {1'b1, 32'h111}) begin
      tests_failed++; $display("FAIL flush_pre_head: got vld=%b data=%h want vld=1 data=111", rd_vld1, rd_data1);
    end
    flush1 = 1'b1; wr_data1 = 32'hBAD; rd_en1 = 1'b1;
    tick();
    flush1 = 1'b0; wr_en1 = 1'b0; rd_en1 = 1'b0;
    tests_run++;
    if ({rd_vld1, wr_vld1, ae1, ovf1, udf1} !== 5'b01101) begin
      tests_failed++; $display("FAIL flush_after: got vld,wr_vld,ae,ovf,udf=%b want 01101", {rd_vld1, wr_vld1, ae1, ovf1, udf1});
    end
`ifdef PREFETCH_FIFO_LEVEL_EN
    tests_run++;
    if (level1 !== '0) begin
      tests_failed++; $display("FAIL flush_level: got %0d want 0", level1);
    end
`endif
    for (int c = 0; c < 8; c++) begin
      tick();
      tests_run++;
      if (rd_vld1 !== 1'b0) begin
        tests_failed++; $display("FAIL flush_stale c=%0d: got vld=%b data=%h want vld=0", c, rd_vld1, rd_data1);
      end
    end
    wr_en1 = 1'b1; wr_data1 = 32'h444;
    tick();
    wr_en1 = 1'b0;
    tick(); tick();
    tests_run++;
    if ({rd_vld1, rd_data1} !== {1'b1, 32'h444}) begin
      tests_failed++; $display("FAIL flush_next_word: got vld=%b data=%h want vld=1 data=444", rd_vld1, rd_data1);
    end
    rd_en1 = 1'b1;
    tick();
    rd_en1 = 1'b0;
    tests_run++;
    if (rd_vld1 !== 1'b0) begin
      tests_failed++; $display("FAIL flush_after_pop: got vld=%b data=%h want vld=0", rd_vld1, rd_data1);
    end
  endtask

  task automatic test_underflow();
    pulse_rst(1);
    tick();
    tests_run++;
    if ({ovf1, udf1, rd_data1} !== {2'b00, 32'h0}) begin
      tests_failed++; $display("FAIL udf_rst_clear: got ovf,udf=%b data=%h want 00 data=0", {ovf1, udf1}, rd_data1);
    end
    rd_en1 = 1'b1;
    tick();
    rd_en1 = 1'b0;
    tests_run++;
    if ({ovf1, udf1} !== 2'b01) begin
      tests_failed++; $display("FAIL udf_set: got ovf,udf=%b want 01", {ovf1, udf1});
    end
    flush1 = 1'b1;
    tick();
    flush1 = 1'b0;
    tick();
    tests_run++;
    if ({ovf1, udf1} !== 2'b01) begin
      tests_failed++; $display("FAIL udf_flush_keep: got ovf,udf=%b want 01", {ovf1, udf1});
    end
    pulse_rst(1);
    tests_run++;
    if ({ovf1, udf1, rd_vld1, wr_vld1} !== 4'b0001) begin
      tests_failed++; $display("FAIL udf_rst_final: got ovf,udf,vld,wr_vld=%b want 0001", {ovf1, udf1, rd_vld1, wr_vld1});
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_thresholds();
    test_fill_overflow();
    test_stream(1);
    test_stream(2);
    test_backpressure();
    test_flush();
    test_underflow();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
